// File: rtl/ps2_keyboard_if.sv
// ============================================================================
// Module      : ps2_keyboard_if
// Description : PS/2 pin pair in, decoded ASCII key strobe and frame-error out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ps2_keyboard_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] key;
    logic       key_valid;
    logic       frame_err;

    modport master (
        output ps2_clk,
        output ps2_data,
        input  key,
        input  key_valid,
        input  frame_err
    );

    modport slave (
        input  ps2_clk,
        input  ps2_data,
        output key,
        output key_valid,
        output frame_err
    );
endinterface

`default_nettype wire

// File: rtl/ps2_keyboard.sv
// ============================================================================
// Module      : ps2_keyboard
// Description : PS/2 frame receiver with odd-parity check, E0/F0 prefix
//               tracking and scan-code-set-2 to ASCII translation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_keyboard #(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int FILTER_LEN     = 4
) (
    input  wire logic      clk,
    input  wire logic      reset,
    ps2_keyboard_if.slave  bus
);

    localparam int                c_TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    logic [1:0]            r_clk_s;
    logic [1:0]            r_dat_s;
    logic [FILTER_LEN-1:0] r_filt_sh;
    logic                  r_filt;
    state_t                r_state;
    state_t                w_state_nxt;
    logic [7:0]            r_shift;
    logic [2:0]            r_bitcnt;
    logic                  r_par_ok;
    logic [c_TMO_W-1:0]    r_tmo_cnt;
    logic                  r_code_rdy;
    logic                  r_frame_err;
    logic                  r_ext;
    logic                  r_brk;
    logic [7:0]            r_key;
    logic                  r_key_valid;
    logic                  w_fall;
    logic                  w_bit;
    logic                  w_tmo;
    logic [8:0]            w_map;

    function automatic logic [8:0] lookup(input logic [7:0] code);
        case (code)
            8'h45: lookup = {1'b1, 8'h30};
            8'h16: lookup = {1'b1, 8'h31};
            8'h1E: lookup = {1'b1, 8'h32};
            8'h26: lookup = {1'b1, 8'h33};
            8'h25: lookup = {1'b1, 8'h34};
            8'h2E: lookup = {1'b1, 8'h35};
            8'h36: lookup = {1'b1, 8'h36};
            8'h3D: lookup = {1'b1, 8'h37};
            8'h3E: lookup = {1'b1, 8'h38};
            8'h46: lookup = {1'b1, 8'h39};
            8'h1C: lookup = {1'b1, 8'h41};
            8'h32: lookup = {1'b1, 8'h42};
            8'h21: lookup = {1'b1, 8'h43};
            8'h23: lookup = {1'b1, 8'h44};
            8'h24: lookup = {1'b1, 8'h45};
            8'h2B: lookup = {1'b1, 8'h46};
            8'h29: lookup = {1'b1, 8'h20};
            8'h4E: lookup = {1'b1, 8'h2D};
            8'h2D: lookup = {1'b1, 8'h72};
            8'h3C: lookup = {1'b1, 8'h55};
            8'h4B: lookup = {1'b1, 8'h4C};
            8'h44: lookup = {1'b1, 8'h6F};
            8'h31: lookup = {1'b1, 8'h6E};
            8'h1B: lookup = {1'b1, 8'h53};
            8'h4D: lookup = {1'b1, 8'h50};
            default: lookup = 9'h000;
        endcase
    endfunction

    // Filtered clock only moves once every filter stage agrees.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_clk_s   <= 2'b11;
            r_dat_s   <= 2'b11;
            r_filt_sh <= '1;
            r_filt    <= 1'b1;
        end else begin
            r_clk_s   <= {r_clk_s[0], bus.ps2_clk};
            r_dat_s   <= {r_dat_s[0], bus.ps2_data};
            r_filt_sh <= {r_filt_sh[FILTER_LEN-2:0], r_clk_s[1]};
            if (&r_filt_sh)
                r_filt <= 1'b1;
            else if (~|r_filt_sh)
                r_filt <= 1'b0;
        end
    end

    assign w_fall = r_filt & ~|r_filt_sh;
    assign w_bit  = r_dat_s[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tmo       = 1'b0;
        if (r_state != S_IDLE && !w_fall && r_tmo_cnt == c_TMO_LAST) begin
            w_tmo       = 1'b1;
            w_state_nxt = S_IDLE;
        end else if (w_fall) begin
            case (r_state)
                S_IDLE:   if (!w_bit) w_state_nxt = S_DATA;
                S_DATA:   if (r_bitcnt == 3'd7) w_state_nxt = S_PARITY;
                S_PARITY: w_state_nxt = S_STOP;
                S_STOP:   w_state_nxt = S_IDLE;
                default:  w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shift     <= 8'h00;
            r_bitcnt    <= 3'd0;
            r_par_ok    <= 1'b0;
            r_tmo_cnt   <= '0;
            r_code_rdy  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_code_rdy  <= 1'b0;
            r_frame_err <= w_tmo;
            if (r_state == S_IDLE || w_fall)
                r_tmo_cnt <= '0;
            else
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            if (w_fall) begin
                case (r_state)
                    S_IDLE: r_bitcnt <= 3'd0;
                    S_DATA: begin
                        r_shift  <= {w_bit, r_shift[7:1]};
                        r_bitcnt <= r_bitcnt + 3'd1;
                    end
                    S_PARITY: r_par_ok <= ^{w_bit, r_shift};
                    S_STOP: begin
                        if (w_bit && r_par_ok)
                            r_code_rdy <= 1'b1;
                        else
                            r_frame_err <= 1'b1;
                    end
                    default: r_bitcnt <= 3'd0;
                endcase
            end
        end
    end

    assign w_map = lookup(r_shift);

    // An error drops pending prefixes so a damaged break cannot eat the next key.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ext       <= 1'b0;
            r_brk       <= 1'b0;
            r_key       <= 8'h20;
            r_key_valid <= 1'b0;
        end else begin
            r_key_valid <= 1'b0;
            if (r_frame_err) begin
                r_ext <= 1'b0;
                r_brk <= 1'b0;
            end else if (r_code_rdy) begin
                if (r_shift == 8'hE0) begin
                    r_ext <= 1'b1;
                end else if (r_shift == 8'hF0) begin
                    r_brk <= 1'b1;
                end else if (r_ext || r_brk) begin
                    r_ext <= 1'b0;
                    r_brk <= 1'b0;
                end else if (w_map[8]) begin
                    r_key       <= w_map[7:0];
                    r_key_valid <= 1'b1;
                end
            end
        end
    end

    assign bus.key       = r_key;
    assign bus.key_valid = r_key_valid;
    assign bus.frame_err = r_frame_err;

endmodule

`default_nettype wire

// File: tb/tb_ps2_keyboard.sv
// ============================================================================
// Module      : tb_ps2_keyboard
// Description : Directed vector bench for the PS/2 keyboard receiver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ps2_keyboard;

    localparam int c_TMO  = 300;
    localparam int c_FL   = 4;
    localparam int c_HALF = 20;

    typedef struct {
        logic [7:0] code;
        logic       bad_par;
        int         dkv;
        int         derr;
        logic [7:0] key;
    } vec_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_kv;
    int   n_err;
    int   n_both;
    int   last_kv_cyc;
    int   last_fall_cyc;
    int   total;
    int   bad;
    vec_t vecs [17];

    ps2_keyboard_if bus ();

    ps2_keyboard #(
        .TIMEOUT_CYCLES (c_TMO),
        .FILTER_LEN     (c_FL)
    ) u_dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        n_kv = 0; n_err = 0; n_both = 0; last_kv_cyc = 0;
    end
    always @(negedge clk) begin
        if (bus.key_valid) begin
            n_kv++;
            last_kv_cyc = cyc;
        end
        if (bus.frame_err) n_err++;
        if (bus.key_valid && bus.frame_err) n_both++;
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        bus.ps2_data = b;
        wait_cyc(c_HALF);
        bus.ps2_clk   = 1'b0;
        last_fall_cyc = cyc;
        wait_cyc(c_HALF);
        bus.ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((~^b) ^ bad_par);
        send_bit(1'b1);
        wait_cyc(c_HALF);
    endtask

    initial begin
        int kv0;
        int e0;
        total = 0;
        bad   = 0;
        vecs[0]  = '{8'h16, 1'b0, 1, 0, 8'h31};
        vecs[1]  = '{8'h1C, 1'b0, 1, 0, 8'h41};
        vecs[2]  = '{8'hF0, 1'b0, 0, 0, 8'h41};
        vecs[3]  = '{8'h1C, 1'b0, 0, 0, 8'h41};
        vecs[4]  = '{8'hE0, 1'b0, 0, 0, 8'h41};
        vecs[5]  = '{8'h75, 1'b0, 0, 0, 8'h41};
        vecs[6]  = '{8'h45, 1'b0, 1, 0, 8'h30};
        vecs[7]  = '{8'h2B, 1'b1, 0, 1, 8'h30};
        vecs[8]  = '{8'h2B, 1'b0, 1, 0, 8'h46};
        vecs[9]  = '{8'h16, 1'b0, 1, 0, 8'h31};
        vecs[10] = '{8'h16, 1'b0, 1, 0, 8'h31};
        vecs[11] = '{8'h12, 1'b0, 0, 0, 8'h31};
        vecs[12] = '{8'hF0, 1'b0, 0, 0, 8'h31};
        vecs[13] = '{8'h55, 1'b1, 0, 1, 8'h31};
        vecs[14] = '{8'h16, 1'b0, 1, 0, 8'h31};
        vecs[15] = '{8'h2D, 1'b0, 1, 0, 8'h72};
        vecs[16] = '{8'h4D, 1'b0, 1, 0, 8'h50};

        rst_n        = 1'b0;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        wait_cyc(5);
        chk("reset_key", bus.key, 8'h20);
        chk("reset_kv", bus.key_valid, 0);
        chk("reset_err", bus.frame_err, 0);
        rst_n = 1'b1;
        wait_cyc(20);

        for (int v = 0; v < 17; v++) begin
            kv0 = n_kv;
            e0  = n_err;
            send_frame(vecs[v].code, vecs[v].bad_par);
            chk($sformatf("vec%0d_kv", v), n_kv - kv0, vecs[v].dkv);
            chk($sformatf("vec%0d_err", v), n_err - e0, vecs[v].derr);
            chk($sformatf("vec%0d_key", v), bus.key, vecs[v].key);
            if (vecs[v].dkv == 1)
                chk($sformatf("vec%0d_latency", v), last_kv_cyc - last_fall_cyc, 2 + c_FL + 2);
        end

        // Short clock glitch with data low must not start a frame.
        kv0 = n_kv; e0 = n_err;
        bus.ps2_data = 1'b0;
        wait_cyc(c_HALF);
        bus.ps2_clk = 1'b0;
        wait_cyc(c_FL - 1);
        bus.ps2_clk = 1'b1;
        wait_cyc(2 * c_TMO);
        bus.ps2_data = 1'b1;
        chk("glitch_err", n_err - e0, 0);
        chk("glitch_kv", n_kv - kv0, 0);
        send_frame(8'h3D, 1'b0);
        chk("glitch_next_key", bus.key, 8'h37);

        // Clock stalls after five bits.
        kv0 = n_kv; e0 = n_err;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'(8'h4E >> i));
        wait_cyc(2 * c_TMO + 100);
        chk("tmo_err", n_err - e0, 1);
        chk("tmo_kv", n_kv - kv0, 0);
        chk("tmo_key", bus.key, 8'h37);
        send_frame(8'h4E, 1'b0);
        chk("tmo_next_key", bus.key, 8'h2D);
        chk("tmo_next_kv", n_kv - kv0, 1);

        // Reset in the middle of a frame that follows a break prefix.
        send_frame(8'hF0, 1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_key", bus.key, 8'h20);
        chk("midrst_kv", bus.key_valid, 0);
        chk("midrst_err", bus.frame_err, 0);
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        wait_cyc(10);
        rst_n = 1'b1;
        wait_cyc(50);
        kv0 = n_kv; e0 = n_err;
        send_frame(8'h29, 1'b0);
        chk("midrst_next_kv", n_kv - kv0, 1);
        chk("midrst_next_key", bus.key, 8'h20);
        chk("midrst_next_err", n_err - e0, 0);

        chk("kv_err_overlap", n_both, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
